// File: rtl/tx_resp_scheduler.sv
// Shares one UART TX serializer between register-file read data and ALU results, round-robin, frame-atomic.
// Optional build macro TX_FRAME_HDR_EN: prefix each frame with a source header byte (RD=A5, ALU=5A).
module tx_resp_scheduler #(
   parameter int WIDTH       = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   RdData,
   input  logic               RdData_Valid,
   input  logic [2*WIDTH-1:0] ALU_OUT,
   input  logic               OUT_Valid,
   input  logic               Busy,
   output logic [WIDTH-1:0]   TX_P_DATA,
   output logic               TX_D_VLD,
   output logic               Overrun,
   output logic               Tx_Err,
   output logic               Idle
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
`ifdef TX_FRAME_HDR_EN
   localparam int NB = 3;
   localparam logic [WIDTH-1:0] HDR_RD  = WIDTH'(8'hA5);
   localparam logic [WIDTH-1:0] HDR_ALU = WIDTH'(8'h5A);
`else
   localparam int NB = 2;
`endif
   localparam int FW = NB * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE} state_t;
   state_t state_q, state_d;

   logic               rd_pend_q, rd_pend_d, alu_pend_q, alu_pend_d;
   logic [WIDTH-1:0]   rd_data_q;
   logic [2*WIDTH-1:0] alu_data_q;
   logic               last_grant_q, last_grant_d;   // 1 = ALU
   logic               gnt_q, gnt_d;
   logic [FW-1:0]      frm_q, frm_d;
   logic [1:0]         left_q, left_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   tx_data_q, tx_data_d;
   logic               tx_vld_q, ovr_q, ovr_d, err_q, err_d;

   logic          any_pend, gnt_sel, grant_go, strobe, timeout, done, cur_src;
   logic          last_strobe, rd_clr, alu_clr, cnt_hit;
   logic [FW-1:0] new_frm;
   logic [1:0]    new_len;

   assign cnt_hit = (cnt_q == CW'(ACK_TIMEOUT - 1));

   // Frame image of the candidate source, lowest byte goes out first
   always_comb begin
`ifdef TX_FRAME_HDR_EN
      if (gnt_sel) begin
         new_frm = {alu_data_q, HDR_ALU};
         new_len = 2'd3;
      end else begin
         new_frm = {{WIDTH{1'b0}}, rd_data_q, HDR_RD};
         new_len = 2'd2;
      end
`else
      if (gnt_sel) begin
         new_frm = alu_data_q;
         new_len = 2'd2;
      end else begin
         new_frm = {{WIDTH{1'b0}}, rd_data_q};
         new_len = 2'd1;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (any_pend && !Busy) state_d = S_WAIT_ACK;
         S_SEND:      state_d = S_WAIT_ACK;
         S_WAIT_ACK:  if (Busy) state_d = S_WAIT_DONE;
                      else if (cnt_hit) state_d = S_IDLE;
         S_WAIT_DONE: if (!Busy) state_d = (left_q != 2'd0) ? S_SEND : S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      any_pend    = rd_pend_q | alu_pend_q;
      gnt_sel     = (rd_pend_q & alu_pend_q) ? ~last_grant_q : alu_pend_q;
      grant_go    = (state_q == S_IDLE) & any_pend & ~Busy;
      strobe      = grant_go | (state_q == S_SEND);
      timeout     = (state_q == S_WAIT_ACK) & ~Busy & cnt_hit;
      done        = (state_q == S_WAIT_DONE) & ~Busy & (left_q == 2'd0);
      cur_src     = grant_go ? gnt_sel : gnt_q;
      last_strobe = (grant_go & (new_len == 2'd1)) | ((state_q == S_SEND) & (left_q == 2'd1));
      rd_clr      = (last_strobe | timeout) & ~cur_src;
      alu_clr     = (last_strobe | timeout) & cur_src;
      Idle        = (state_q == S_IDLE) & ~any_pend;
   end

   // A capture on the clearing edge wins over the clear and is not an overrun
   always_comb begin
      rd_pend_d    = RdData_Valid | (rd_pend_q & ~rd_clr);
      alu_pend_d   = OUT_Valid | (alu_pend_q & ~alu_clr);
      ovr_d        = ovr_q | (RdData_Valid & rd_pend_q & ~rd_clr) | (OUT_Valid & alu_pend_q & ~alu_clr);
      err_d        = err_q | timeout;
      last_grant_d = done ? gnt_q : last_grant_q;
      gnt_d        = grant_go ? gnt_sel : gnt_q;
      tx_data_d    = tx_data_q;
      frm_d        = frm_q;
      left_d       = left_q;
      if (grant_go) begin
         tx_data_d = new_frm[WIDTH-1:0];
         frm_d     = new_frm >> WIDTH;
         left_d    = new_len - 2'd1;
      end else if (state_q == S_SEND) begin
         tx_data_d = frm_q[WIDTH-1:0];
         frm_d     = frm_q >> WIDTH;
         left_d    = left_q - 2'd1;
      end
      if (strobe)
         cnt_d = '0;
      else if ((state_q == S_WAIT_ACK) && (cnt_q != CW'(ACK_TIMEOUT)))
         cnt_d = cnt_q + CW'(1);
      else
         cnt_d = cnt_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_pend_q    <= 1'b0;
         alu_pend_q   <= 1'b0;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         left_q       <= 2'd0;
         cnt_q        <= '0;
         tx_data_q    <= '0;
         tx_vld_q     <= 1'b0;
         ovr_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rd_pend_q    <= rd_pend_d;
         alu_pend_q   <= alu_pend_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         left_q       <= left_d;
         cnt_q        <= cnt_d;
         tx_data_q    <= tx_data_d;
         tx_vld_q     <= strobe;
         ovr_q        <= ovr_d;
         err_q        <= err_d;
      end
   end

   // Holding registers and frozen frame carry no reset; pending flags qualify them
   always_ff @(posedge CLK) begin
      if (RdData_Valid) rd_data_q <= RdData;
      if (OUT_Valid)    alu_data_q <= ALU_OUT;
      frm_q <= frm_d;
   end

   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign Overrun   = ovr_q;
   assign Tx_Err    = err_q;

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Self-checking bench for tx_resp_scheduler: directed scenarios then random traffic against a frame-level model.
module tb_tx_resp_scheduler;
   localparam int WIDTH = 8;
   localparam int TO    = 16;
`ifdef TX_FRAME_HDR_EN
   localparam int RD_BYTES = 2;
`else
   localparam int RD_BYTES = 1;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RdData = '0;
   logic        RdData_Valid = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        OUT_Valid = 1'b0;
   logic        Busy;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD, Overrun, Tx_Err, Idle;

   tx_resp_scheduler #(.WIDTH(WIDTH), .ACK_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .Busy(Busy),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Overrun(Overrun),
      .Tx_Err(Tx_Err), .Idle(Idle)
   );

   always #5 CLK = ~CLK;

   // UART TX stand-in: Busy rises half a cycle after a strobe and stays high L cycles
   int   L = 4;
   logic busy_en = 1'b1;
   int   bcnt = 0;
   assign Busy = busy_en && (bcnt > 0);
   always @(negedge CLK) begin
      if (RST)                bcnt <= 0;
      else if (TX_D_VLD)      bcnt <= L;
      else if (bcnt > 0)      bcnt <= bcnt - 1;
   end

   int checks = 0;
   int errors = 0;
   int e = 0;

   // Reference model: pending slots plus a byte queue for the frame on the wire
   logic       m_rdp, m_alup, m_last, m_src, m_active, m_vld, m_ovr, m_err;
   logic [7:0] m_rdd, m_data;
   logic [15:0] m_alud;
   logic [7:0] m_q[$];
   int         m_abort_e, m_idle_from, m_next_free, m_next_e;

   logic [7:0] obs[$];
   logic [7:0] exp_q[$];

   function automatic void m_reset();
      m_rdp = 0; m_alup = 0; m_last = 1; m_src = 0; m_active = 0;
      m_vld = 0; m_data = 0; m_ovr = 0; m_err = 0;
      m_q.delete();
      m_abort_e = -1; m_idle_from = e; m_next_free = e + 1; m_next_e = -1;
   endfunction

   function automatic void m_send();
      m_data = m_q.pop_front();
      m_vld  = 1;
      if (!busy_en) begin
         m_abort_e = e + TO; m_next_free = e + TO + 1; m_idle_from = e + TO;
      end
      if (m_q.size() == 0) begin
         m_active = 0;
         if (m_src) m_alup = 0; else m_rdp = 0;
         if (busy_en) begin
            m_last = m_src; m_idle_from = e + L + 1; m_next_free = e + L + 2;
         end
      end else if (busy_en) begin
         m_next_e = e + L + 2;
      end
   endfunction

   function automatic void m_edge(input logic rv, input logic [7:0] rd, input logic ov,
                                  input logic [15:0] ao, input logic rst);
      if (rst) begin
         m_reset();
         return;
      end
      m_vld = 0;
      if (m_abort_e == e) begin
         m_err = 1;
         if (m_src) m_alup = 0; else m_rdp = 0;
         m_active = 0; m_q.delete(); m_abort_e = -1;
         m_idle_from = e; m_next_free = e + 1;
      end else if (m_active && busy_en && e == m_next_e) begin
         m_send();
      end else if (!m_active && e >= m_next_free && (m_rdp || m_alup)) begin
         m_src = (m_rdp && m_alup) ? !m_last : m_alup;
         m_q.delete();
`ifdef TX_FRAME_HDR_EN
         m_q.push_back(m_src ? 8'h5A : 8'hA5);
`endif
         if (m_src) begin
            m_q.push_back(m_alud[7:0]);
            m_q.push_back(m_alud[15:8]);
         end else begin
            m_q.push_back(m_rdd);
         end
         m_active = 1;
         m_send();
      end
      if (rv) begin
         if (m_rdp) m_ovr = 1;
         m_rdp = 1; m_rdd = rd;
      end
      if (ov) begin
         if (m_alup) m_ovr = 1;
         m_alup = 1; m_alud = ao;
      end
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, got, exp);
      end
   endtask

   task automatic step(input logic rv, input logic [7:0] rd, input logic ov,
                       input logic [15:0] ao, input logic rst);
      RdData_Valid = rv; RdData = rd; OUT_Valid = ov; ALU_OUT = ao; RST = rst;
      @(posedge CLK);
      e++;
      m_edge(rv, rd, ov, ao, rst);
      #1;
      chk("tx_d_vld",  16'(TX_D_VLD),  16'(m_vld));
      chk("tx_p_data", 16'(TX_P_DATA), 16'(m_data));
      chk("idle",      16'(Idle),      16'(!m_active && e >= m_idle_from && !m_rdp && !m_alup));
      chk("overrun",   16'(Overrun),   16'(m_ovr));
      chk("tx_err",    16'(Tx_Err),    16'(m_err));
      if (TX_D_VLD === 1'b1) obs.push_back(TX_P_DATA);
      RdData_Valid = 0; OUT_Valid = 0; RST = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 16'h0000, 0);
   endtask

   function automatic void ex_rd(input logic [7:0] b);
`ifdef TX_FRAME_HDR_EN
      exp_q.push_back(8'hA5);
`endif
      exp_q.push_back(b);
   endfunction

   function automatic void ex_alu(input logic [15:0] w);
`ifdef TX_FRAME_HDR_EN
      exp_q.push_back(8'h5A);
`endif
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
   endfunction

   task automatic chk_seq(input string tag);
      chk({tag, "_len"}, 16'(obs.size()), 16'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
         chk(tag, 16'(obs[i]), 16'(exp_q[i]));
      obs.delete();
      exp_q.delete();
   endtask

   initial begin
      m_reset();
      step(0, 8'h00, 0, 16'h0000, 1);
      step(0, 8'h00, 0, 16'h0000, 1);
      chk("reset_idle", 16'(Idle), 16'(1));
      obs.delete();

      // Single read-data response with two-cycle latency
      step(1, 8'h3C, 0, 16'h0000, 0);
      step(0, 8'h00, 0, 16'h0000, 0);
      chk("t1_latency", 16'(TX_D_VLD), 16'(1));
      idle(30);
      chk("t1_idle", 16'(Idle), 16'(1));
      ex_rd(8'h3C);
      chk_seq("t1_seq");

      // ALU result, low byte first
      step(0, 8'h00, 1, 16'hBEEF, 0);
      idle(30);
      ex_alu(16'hBEEF);
      chk_seq("t2_seq");

      // Tie goes to RD first; a second tie right after goes to ALU
      step(1, 8'h11, 1, 16'h2233, 0);
      idle((RD_BYTES - 1) * (L + 2) + 2);
      step(1, 8'h44, 0, 16'h0000, 0);
      idle(50);
      ex_rd(8'h11); ex_alu(16'h2233); ex_rd(8'h44);
      chk_seq("t3_seq");

      // Two reads while the ALU frame owns the line
      step(0, 8'h00, 1, 16'hA1B2, 0);
      idle(2);
      step(1, 8'h01, 0, 16'h0000, 0);
      idle(1);
      step(1, 8'h02, 0, 16'h0000, 0);
      idle(40);
      chk("t4_overrun", 16'(Overrun), 16'(1));
      ex_alu(16'hA1B2); ex_rd(8'h02);
      chk_seq("t4_seq");

      // Busy never answers: frame aborted after the acknowledge timeout
      step(0, 8'h00, 0, 16'h0000, 1);
      obs.delete();
      busy_en = 1'b0;
      step(1, 8'h77, 0, 16'h0000, 0);
      idle(TO + 6);
      chk("t5_tx_err", 16'(Tx_Err), 16'(1));
      chk("t5_idle", 16'(Idle), 16'(1));
`ifdef TX_FRAME_HDR_EN
      exp_q.push_back(8'hA5);
`else
      exp_q.push_back(8'h77);
`endif
      chk_seq("t5_seq");
      busy_en = 1'b1;
      step(0, 8'h00, 0, 16'h0000, 1);

      // Reset in the middle of an ALU frame
      obs.delete();
      step(0, 8'h00, 1, 16'hCAFE, 0);
      idle(3);
      step(0, 8'h00, 0, 16'h0000, 1);
      chk("t6_vld", 16'(TX_D_VLD), 16'(0));
      chk("t6_data", 16'(TX_P_DATA), 16'(0));
      chk("t6_idle", 16'(Idle), 16'(1));
      chk("t6_ovr", 16'(Overrun), 16'(0));
      chk("t6_err", 16'(Tx_Err), 16'(0));
      idle(20);
`ifdef TX_FRAME_HDR_EN
      exp_q.push_back(8'h5A);
`else
      exp_q.push_back(8'hFE);
`endif
      chk_seq("t6_seq");

      // Random traffic with a randomly chosen UART byte time
      L = $urandom_range(2, 6);
      step(0, 8'h00, 0, 16'h0000, 1);
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 6) == 0, 8'($urandom), ($urandom % 7) == 0, 16'($urandom),
              ($urandom % 400) == 0);
         if (obs.size() > 64) obs.delete();
      end
      idle(40);
      chk("final_idle", 16'(Idle), 16'(!m_rdp && !m_alup && !m_active && e >= m_idle_from));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
